// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   2^INDEX_BITS lines of one 32-bit word each. Load hits return data in the
//   same cycle. Load misses fill from memory and then retire as a hit. Stores
//   always go to memory; they update the line only when it already holds the
//   address.
//
// Ports:
//   CLK, RST_N           clock (rising edge) and asynchronous active-low reset
//   CPU_REQ/CPU_WE       access request, 1 = store / 0 = load
//   CPU_A/CPU_WD         byte address (bits [1:0] ignored) and store data
//   CPU_RD/CPU_STALL     load data and stall back to the CPU
//   MEM_REQ/MEM_WE       memory request and write strobe
//   MEM_A/MEM_WD         word-aligned memory address and write data
//   MEM_RD/MEM_ACK       memory read data and completion strobe
//   HIT_CNT/MISS_CNT     wrapping load-hit / load-miss counters
//   DBG_STATE            FSM state (0 = IDLE, 1 = FILL, 2 = WRITE)
//
// Handshake: CPU_REQ is a valid that stays asserted, with the CPU inputs held
// stable, until a cycle with CPU_STALL=0 retires it. MEM_REQ is a valid that
// stays asserted, with address and data stable, until the cycle MEM_ACK=1
// completes it. MEM_ACK outside FILL/WRITE means nothing.
module data_cache #(
    parameter int A_WIDTH    = 28,
    parameter int INDEX_BITS = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CPU_REQ,
    input  logic               CPU_WE,
    input  logic [A_WIDTH-1:0] CPU_A,
    input  logic [31:0]        CPU_WD,
    output logic [31:0]        CPU_RD,
    output logic               CPU_STALL,
    output logic               MEM_REQ,
    output logic               MEM_WE,
    output logic [A_WIDTH-1:0] MEM_A,
    output logic [31:0]        MEM_WD,
    input  logic [31:0]        MEM_RD,
    input  logic               MEM_ACK,
    output logic [31:0]        HIT_CNT,
    output logic [31:0]        MISS_CNT,
    output logic [1:0]         DBG_STATE
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = A_WIDTH - INDEX_BITS - 2;
    localparam logic [A_WIDTH-1:0] WORD_MASK = {{(A_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  load_hit, load_miss, fill_done, write_done;

    assign idx = CPU_A[INDEX_BITS+1:2];
    assign tag = CPU_A[A_WIDTH-1:INDEX_BITS+2];
    assign hit = valid[idx] && (tag_mem[idx] == tag);

    // The CPU holds its address across the whole transaction, so the memory
    // address and write data can come straight from the CPU side.
    assign CPU_RD    = data_mem[idx];
    assign MEM_A     = CPU_A & WORD_MASK;
    assign MEM_WD    = CPU_WD;
    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        CPU_STALL  = 1'b0;
        MEM_REQ    = 1'b0;
        MEM_WE     = 1'b0;
        load_hit   = 1'b0;
        load_miss  = 1'b0;
        fill_done  = 1'b0;
        write_done = 1'b0;
        case (state)
            IDLE: begin
                if (CPU_REQ) begin
                    if (CPU_WE) begin
                        CPU_STALL = 1'b1;
                        state_nxt = WRITE;
                    end else if (hit) begin
                        load_hit = 1'b1;
                    end else begin
                        CPU_STALL = 1'b1;
                        load_miss = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                MEM_REQ   = 1'b1;
                CPU_STALL = 1'b1;
                if (MEM_ACK) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                MEM_REQ   = 1'b1;
                MEM_WE    = 1'b1;
                // The store retires in its ACK cycle, so the stall drops there.
                CPU_STALL = !MEM_ACK;
                if (MEM_ACK) begin
                    write_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HIT_CNT  <= 32'd0;
            MISS_CNT <= 32'd0;
        end else begin
            if (load_hit) begin
                HIT_CNT <= HIT_CNT + 32'd1;
            end
            if (load_miss) begin
                MISS_CNT <= MISS_CNT + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them.
    // A fill replaces whatever line sat at the index.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data_mem[idx] <= MEM_RD;
            tag_mem[idx]  <= tag;
        end else if (write_done && hit) begin
            data_mem[idx] <= CPU_WD;
        end
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter A_WIDTH, default 28: byte-address width on both CPU and memory sides.
REQ-002 Parameter INDEX_BITS, default 6: log2 of the number of lines (64 lines, one 32-bit word per line).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 CPU_REQ  input  1  CPU access request valid this cycle.
REQ-006 CPU_WE  input  1  1 = store, 0 = load; qualified by CPU_REQ.
REQ-007 CPU_A  input  A_WIDTH  CPU byte address; bits [1:0] ignored (word access only).
REQ-008 CPU_WD  input  32  store data.
REQ-009 CPU_RD  output  32  load data; valid when CPU_REQ=1, CPU_WE=0 and CPU_STALL=0.
REQ-010 CPU_STALL  output  1  CPU must hold CPU_REQ/CPU_WE/CPU_A/CPU_WD stable while high.
REQ-011 MEM_REQ  output  1  memory request valid.
REQ-012 MEM_WE  output  1  memory write strobe; qualified by MEM_REQ.
REQ-013 MEM_A  output  A_WIDTH  word-aligned memory byte address (bits [1:0] = 0).
REQ-014 MEM_WD  output  32  memory write data, little-endian word.
REQ-015 MEM_RD  input  32  memory read data; sampled only when MEM_ACK=1.
REQ-016 MEM_ACK  input  1  memory completes the current request this cycle.
REQ-017 HIT_CNT  output  32  number of completed load hits.
REQ-018 MISS_CNT  output  32  number of load misses.

Function
REQ-019 Address split: index = CPU_A[INDEX_BITS+1:2]; tag = CPU_A[A_WIDTH-1:INDEX_BITS+2]; hit = valid[index] and tag match.
REQ-020 FSM states: IDLE, FILL, WRITE.
REQ-021 IDLE, no request: CPU_STALL=0, MEM_REQ=0; state held.
REQ-022 IDLE, load hit: CPU_RD = line data combinationally in the same cycle; CPU_STALL=0; HIT_CNT increments at the edge.
REQ-023 IDLE, load miss: CPU_STALL=1 combinationally in the same cycle; next state FILL; MISS_CNT increments at the edge.
REQ-024 IDLE, store (hit or miss): CPU_STALL=1 combinationally in the same cycle; next state WRITE.
REQ-025 FILL: MEM_REQ=1, MEM_WE=0, MEM_A = {CPU_A[A_WIDTH-1:2],2'b00}, CPU_STALL=1; request held until MEM_ACK.
REQ-026 FILL with MEM_ACK=1: MEM_RD written to data[index], tag stored, valid[index] set; next state IDLE; the following IDLE cycle is a load hit returning MEM_RD (miss latency = memory latency + 1 cycle).
REQ-027 WRITE: MEM_REQ=1, MEM_WE=1, MEM_A as REQ-025, MEM_WD=CPU_WD, CPU_STALL=1 until MEM_ACK.
REQ-028 WRITE with MEM_ACK=1: on hit, data[index] updated to CPU_WD; on miss, cache unchanged (write-through, no-write-allocate); next state IDLE with CPU_STALL=0 in that ACK cycle, so the store retires.
REQ-029 MEM_ACK while in IDLE ignored; MEM_ACK in the same cycle a request enters FILL/WRITE has no effect until the FSM is in that state.
REQ-030 Conflicting line (same index, different tag) on fill: old line replaced unconditionally.
REQ-031 HIT_CNT and MISS_CNT wrap from 32'hFFFFFFFF to 0; no saturation.
REQ-032 While CPU_STALL=1, CPU input changes are a protocol violation; behaviour is undefined and not checked.

Reset
REQ-033 RST_N=0 asynchronously: state=IDLE, all valid bits=0, HIT_CNT=0, MISS_CNT=0, MEM_REQ=0, MEM_WE=0, CPU_STALL=0 (unless CPU_REQ asserted, per REQ-023/024).
REQ-034 Data and tag arrays are not reset.
REQ-035 Reset during FILL or WRITE abandons the transaction: MEM_REQ drops immediately; no line written; a late MEM_ACK after reset release is ignored per REQ-029.

Verification
REQ-036 Reset, then load A=0x10000 with memory returning 0xDEADBEEF after 3 cycles -> STALL high 4 cycles, CPU_RD=0xDEADBEEF, MISS_CNT=1, HIT_CNT=1.
REQ-037 Repeat load 0x10000 -> no stall, CPU_RD=0xDEADBEEF same cycle, MEM_REQ stays 0, HIT_CNT=2.
REQ-038 Store 0x12345678 to 0x10000 (hit), ACK after 2 cycles -> MEM_WE=1, MEM_WD=0x12345678; subsequent load hits with 0x12345678.
REQ-039 Store to 0x20000 (miss) then load 0x20000 -> store does not allocate; load misses, MISS_CNT increments.
REQ-040 Load 0x10000 then 0x10100 (same index, different tag) then 0x10000 -> three misses, line replaced each time.
REQ-041 Assert RST_N=0 mid-FILL, release, pulse MEM_ACK -> MEM_REQ=0, state IDLE, valid clear, counters 0, no line written.
